div_sequencer: RTL and testbench

//  Multi-cycle 16-bit signed/unsigned divider with its own sequencing FSM, sitting beside the EX-stage ALU.

---
 rtl/div_sequencer_pkg.sv | 19 +
 rtl/div_sequencer_step.sv | 24 ++
 rtl/div_sequencer.sv | 176 +++++++++++++++++
 tb/tb_div_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle divider: default widths, FSM
// state encoding and the quotient value reported on divide-by-zero.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = 5;

    // Quotient presented when the divisor is zero
    localparam logic [DIV_WIDTH-1:0] DIV_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } divState_t;

endpackage

// File: rtl/div_sequencer_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the
// difference and emit a 1 quotient bit when it does not go negative.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_partRem,
    input  logic             i_dvdBit,
    input  logic [WIDTH:0]   i_divisor,
    output logic [WIDTH-1:0] o_nextRem,
    output logic             o_qBit
);

    logic [WIDTH:0] w_shift;

    // The shifted remainder needs one extra bit; after a successful
    // subtract the result is below the divisor, so it fits in WIDTH bits.
    always_comb begin
        w_shift   = {i_partRem, i_dvdBit};
        o_qBit    = (w_shift >= i_divisor);
        o_nextRem = o_qBit ? WIDTH'(w_shift - i_divisor) : w_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned restoring divider with its own sequencing FSM.
// It sits beside the EX-stage ALU, stalls the pipeline while it works and
// presents quotient/remainder together with a one-cycle Done pulse.
// Optional build macro: DIV_EARLY_EXIT_EN skips the iteration loop when
// |dividend| < |divisor|, which finishes in SETUP with quotient 0.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_divStall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_divByZero
);

    divState_t        r_state;
    logic [CNT_W-1:0] r_count;

    // Operands as captured at launch
    logic [WIDTH-1:0] r_dvdRaw;
    logic [WIDTH-1:0] r_dvsRaw;
    logic             r_signed;

    // Iteration datapath: quotient bits shift in as dividend bits shift out
    logic [WIDTH-1:0] r_quotShift;
    logic [WIDTH-1:0] r_partRem;
    logic [WIDTH:0]   r_dvsMag;
    logic             r_qNeg;
    logic             r_rNeg;

    // Registered outputs
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_divByZero;

    logic [WIDTH-1:0] w_dvdMag;
    logic [WIDTH-1:0] w_dvsMag;
    logic             w_divZero;
    logic [WIDTH-1:0] w_stepRem;
    logic             w_qBit;

    // Magnitudes as unsigned WIDTH-bit values; the most negative operand
    // negates to 2^(WIDTH-1), which is exact when read as unsigned.
    always_comb begin
        w_dvdMag  = (r_signed && r_dvdRaw[WIDTH-1]) ? -r_dvdRaw : r_dvdRaw;
        w_dvsMag  = (r_signed && r_dvsRaw[WIDTH-1]) ? -r_dvsRaw : r_dvsRaw;
        w_divZero = (r_dvsRaw == '0);
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_partRem(r_partRem),
        .i_dvdBit (r_quotShift[WIDTH-1]),
        .i_divisor(r_dvsMag),
        .o_nextRem(w_stepRem),
        .o_qBit   (w_qBit)
    );

    // Sequencing FSM with operand capture, iteration and sign fix-up; abort
    // overrides everything, and DONE always returns to IDLE so a Start still
    // held by the finishing instruction is not taken as a new launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_dvdRaw    <= '0;
            r_dvsRaw    <= '0;
            r_signed    <= 1'b0;
            r_quotShift <= '0;
            r_partRem   <= '0;
            r_dvsMag    <= '0;
            r_qNeg      <= 1'b0;
            r_rNeg      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_divByZero <= 1'b0;
        end else if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_dvdRaw <= i_dividend;
                        r_dvsRaw <= i_divisor;
                        r_signed <= i_signed;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_qNeg <= r_signed & (r_dvdRaw[WIDTH-1] ^ r_dvsRaw[WIDTH-1]);
                    r_rNeg <= r_signed & r_dvdRaw[WIDTH-1];
                    if (w_divZero) begin
                        r_quot      <= '1;
                        r_rem       <= r_dvdRaw;
                        r_divByZero <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (w_dvdMag < w_dvsMag) begin
                        r_quot      <= '0;
                        r_rem       <= r_dvdRaw;
                        r_divByZero <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end
`endif
                    else begin
                        r_partRem   <= '0;
                        r_quotShift <= w_dvdMag;
                        r_dvsMag    <= {1'b0, w_dvsMag};
                        r_count     <= CNT_W'(WIDTH - 1);
                        r_state     <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    r_partRem   <= w_stepRem;
                    r_quotShift <= {r_quotShift[WIDTH-2:0], w_qBit};
                    if (r_count == '0) begin
                        r_state <= ST_FIXUP;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                ST_FIXUP: begin
                    r_quot      <= r_qNeg ? -r_quotShift : r_quotShift;
                    r_rem       <= r_rNeg ? -r_partRem : r_partRem;
                    r_divByZero <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The launch cycle stalls combinationally; later busy cycles are registered
    always_comb begin
        o_divStall  = r_busy | ((r_state == ST_IDLE) & i_start & ~i_abort);
        o_done      = r_done;
        o_quotient  = r_quot;
        o_remainder = r_rem;
        o_divByZero = r_divByZero;
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: table of divides with hand-computed
// results and latencies, plus abort, reset and IDLE start/abort sequences.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int W       = 16;
    localparam int FULL_LAT = W + 3;
`ifdef DIV_EARLY_EXIT_EN
    localparam int SHORT_LAT = 2;
`else
    localparam int SHORT_LAT = W + 3;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         o_divStall;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_divByZero;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[17];

    div_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_signed   (sgn),
        .i_abort    (abort),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_divStall (o_divStall),
        .o_done     (o_done),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder),
        .o_divByZero(o_divByZero)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Launch one divide, hold Start through DONE, check result, latency,
    // stall count and that the Done pulse lasts one cycle without relaunch
    task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic [W-1:0] q, input logic [W-1:0] r,
                                 input logic dbz, input int lat);
        int cyc = 0;
        int stalls = 0;
        int doneAt = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn = s;
        dividend = a;
        divisor = b;
        while (doneAt < 0 && cyc < 40) begin
            @(negedge clk);
            if (o_done) begin
                doneAt = cyc;
                checkOutput({tag, " stallInDone"}, {31'd0, o_divStall}, 32'd0);
                checkOutput({tag, " quotient"}, {16'd0, o_quotient}, {16'd0, q});
                checkOutput({tag, " remainder"}, {16'd0, o_remainder}, {16'd0, r});
                checkOutput({tag, " divByZero"}, {31'd0, o_divByZero}, {31'd0, dbz});
            end else if (o_divStall) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            if (doneAt < 0) cyc++;
            dividend = ~a;
            divisor = ~b;
            sgn = ~s;
        end
        start = 1'b0;
        checkOutput({tag, " doneCycle"}, doneAt, lat);
        checkOutput({tag, " stallCycles"}, stalls, lat);
        @(negedge clk);
        checkOutput({tag, " donePulse"}, {31'd0, o_done}, 32'd0);
        checkOutput({tag, " stallAfter"}, {31'd0, o_divStall}, 32'd0);
        checkOutput({tag, " quotHeld"}, {16'd0, o_quotient}, {16'd0, q});
    endtask

    initial begin
        int sawDone;

        vecs[0]  = '{16'd100,   16'd7,     1'b0, 16'd14,   16'd2,    1'b0, FULL_LAT};
        vecs[1]  = '{16'hFFF9,  16'd2,     1'b1, 16'hFFFD, 16'hFFFF, 1'b0, FULL_LAT};
        vecs[2]  = '{16'h8000,  16'hFFFF,  1'b1, 16'h8000, 16'h0000, 1'b0, FULL_LAT};
        vecs[3]  = '{16'd5,     16'd0,     1'b0, DIV_ONES, 16'd5,    1'b1, 2};
        vecs[4]  = '{16'd5,     16'd0,     1'b1, DIV_ONES, 16'd5,    1'b1, 2};
        vecs[5]  = '{16'd3,     16'd9,     1'b0, 16'd0,    16'd3,    1'b0, SHORT_LAT};
        vecs[6]  = '{16'hFFFF,  16'd1,     1'b0, 16'hFFFF, 16'd0,    1'b0, FULL_LAT};
        vecs[7]  = '{16'd7,     16'hFFFE,  1'b1, 16'hFFFD, 16'd1,    1'b0, FULL_LAT};
        vecs[8]  = '{16'hFFF9,  16'hFFFE,  1'b1, 16'd3,    16'hFFFF, 1'b0, FULL_LAT};
        vecs[9]  = '{16'hFFF9,  16'd2,     1'b0, 16'h7FFC, 16'd1,    1'b0, FULL_LAT};
        vecs[10] = '{16'd1000,  16'd3,     1'b0, 16'd333,  16'd1,    1'b0, FULL_LAT};
        vecs[11] = '{16'h8000,  16'd0,     1'b1, DIV_ONES, 16'h8000, 1'b1, 2};
        vecs[12] = '{16'hFFFD,  16'd7,     1'b1, 16'd0,    16'hFFFD, 1'b0, SHORT_LAT};
        vecs[13] = '{16'h8000,  16'hFFFF,  1'b0, 16'd0,    16'h8000, 1'b0, SHORT_LAT};
        vecs[14] = '{16'd0,     16'd5,     1'b0, 16'd0,    16'd0,    1'b0, SHORT_LAT};
        vecs[15] = '{16'hFFFF,  16'hFFFF,  1'b1, 16'd1,    16'd0,    1'b0, FULL_LAT};
        vecs[16] = '{16'hFFFF,  16'hFFFF,  1'b0, 16'd1,    16'd0,    1'b0, FULL_LAT};

        // Reset state
        #3;
        checkOutput("reset stall", {31'd0, o_divStall}, 32'd0);
        checkOutput("reset done", {31'd0, o_done}, 32'd0);
        checkOutput("reset quotient", {16'd0, o_quotient}, 32'd0);
        checkOutput("reset remainder", {16'd0, o_remainder}, 32'd0);
        checkOutput("reset divByZero", {31'd0, o_divByZero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                          vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);
        end

        // Abort during iteration of 1000/3
        $display("[TB] abort sequence");
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn = 1'b0;
        dividend = 16'd1000;
        divisor = 16'd3;
        repeat (8) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort stallCycle8", {31'd0, o_divStall}, 32'd1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort stallCycle9", {31'd0, o_divStall}, 32'd0);
        sawDone = 0;
        repeat (25) begin
            @(negedge clk);
            if (o_done) sawDone++;
        end
        checkOutput("abort noDone", sawDone, 0);
        applyStimulus("afterAbort", 16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, FULL_LAT);

        // Abort wins over Start in IDLE
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        dividend = 16'd40;
        divisor = 16'd4;
        @(negedge clk);
        checkOutput("idleAbort stall", {31'd0, o_divStall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        sawDone = 0;
        repeat (22) begin
            @(negedge clk);
            if (o_done || o_divStall) sawDone++;
        end
        checkOutput("idleAbort noLaunch", sawDone, 0);

        // Leave nonzero results and divByZero set, then reset mid-divide
        applyStimulus("preReset", 16'd7, 16'd0, 1'b1, DIV_ONES, 16'd7, 1'b1, 2);
        $display("[TB] reset sequence");
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn = 1'b0;
        dividend = 16'd1000;
        divisor = 16'd3;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("midReset stall", {31'd0, o_divStall}, 32'd0);
        checkOutput("midReset done", {31'd0, o_done}, 32'd0);
        checkOutput("midReset quotient", {16'd0, o_quotient}, 32'd0);
        checkOutput("midReset remainder", {16'd0, o_remainder}, 32'd0);
        checkOutput("midReset divByZero", {31'd0, o_divByZero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawDone = 0;
        repeat (22) begin
            @(negedge clk);
            if (o_done || o_divStall) sawDone++;
        end
        checkOutput("midReset noResidual", sawDone, 0);
        applyStimulus("afterReset", 16'd9, 16'd4, 1'b0, 16'd2, 16'd1, 1'b0, FULL_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
